// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared types and constants for the PLL reset sequencer.
//   pll_state_e  : 2-bit FSM state encoding (also exported on the debug port)
//   LOST_CNT_W   : width of the lock-loss event counter
//   LOST_CNT_MAX : saturation value of the lock-loss counter
//   sat_inc()    : saturating increment for the lock-loss counter
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned             LOST_CNT_W   = 8;
  localparam logic [LOST_CNT_W-1:0]   LOST_CNT_MAX = '1;

  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (v == LOST_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
// Two-flop synchronizer bringing the asynchronous PLL lock indication into
// the reference clock domain. No reset: the output is only meaningful after
// two refclk edges, which the sequencer covers by ignoring it in PLL_RST.
// Ports:
//   refclk : sampling clock
//   d      : asynchronous input
//   q      : synchronized output, 2-cycle latency
// ---------------------------------------------------------------------------
module pll_lock_sync (
  input  logic refclk,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge refclk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Power-up and lock supervisor for the board PLL. Pulses the PLL reset,
// waits for a stable lock, releases the system reset, and re-runs the
// sequence on lock loss, on timeout, or on request. Counts lock losses.
//
// Build option:
//   PLL_RESET_SEQ_AUTO_RELOCK_EN  defined   -> lock loss in RUN pulses pll_rst
//                                 undefined -> lock loss in RUN waits in
//                                              WAIT_LOCK for a self-relock
// Ports:
//   refclk        : reference clock, only clock
//   rst           : synchronous active-high reset
//   pll_locked    : PLL lock indication (asynchronous)
//   relock_req    : single-cycle request to re-run the lock sequence
//   pll_rst       : PLL reset, active-high
//   sys_rst       : system reset, active-high
//   ready         : locked and stable (== !sys_rst)
//   timeout       : sticky WAIT_LOCK timeout flag
//   lock_lost_cnt : saturating count of lock losses seen in RUN
//   state         : current FSM state (debug)
// ---------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned CNT_W               = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  timeout,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output logic [1:0]            state
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

`ifdef PLL_RESET_SEQ_AUTO_RELOCK_EN
  localparam pll_state_e LOSS_TARGET = ST_PLL_RST;
`else
  localparam pll_state_e LOSS_TARGET = ST_WAIT_LOCK;
`endif

  logic                  locked_s;
  pll_state_e            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  timeout_q, timeout_d;
  logic [LOST_CNT_W-1:0] lost_q,    lost_d;
  logic                  cnt_inc;

  pll_lock_sync u_lock_sync (
    .refclk (refclk),
    .d      (pll_locked),
    .q      (locked_s)
  );

  // State register
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      lost_q    <= lost_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    lost_d    = lost_q;
    cnt_inc   = 1'b0;

    unique case (state_q)
      // locked_s is deliberately not looked at here: the synchronizer has
      // no reset and may still be flushing.
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   cnt_inc = 1'b1;
      end

      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_d = ST_PLL_RST;
        end else if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_PLL_RST;
          timeout_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      // A drop here is a failed settle, not a lock loss: not counted.
      ST_STABLE: begin
        if (relock_req)                state_d = ST_PLL_RST;
        else if (!locked_s)            state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        else                           cnt_inc = 1'b1;
      end

      // Lock loss outranks a coincident relock request so it is counted.
      ST_RUN: begin
        if (!locked_s) begin
          lost_d  = sat_inc(lost_q);
          state_d = LOSS_TARGET;
        end else if (relock_req) begin
          state_d = ST_PLL_RST;
        end
      end

      default: state_d = ST_PLL_RST;
    endcase

    // The shared counter restarts from zero on every state change.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_inc)       cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  // Output decode from the state register
  always_comb begin
    pll_rst       = (state_q == ST_PLL_RST);
    sys_rst       = (state_q != ST_RUN);
    ready         = (state_q == ST_RUN);
    timeout       = timeout_q;
    lock_lost_cnt = lost_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  localparam int unsigned PR = 4;
  localparam int unsigned ST = 8;
  localparam int unsigned TO = 32;

`ifdef PLL_RESET_SEQ_AUTO_RELOCK_EN
  localparam logic [31:0] LOSS_STATE = 32'd0;
  localparam logic [31:0] LOSS_PULSE = 32'd4;
`else
  localparam logic [31:0] LOSS_STATE = 32'd1;
  localparam logic [31:0] LOSS_PULSE = 32'd0;
`endif

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout;
  logic [7:0] lock_lost_cnt;
  logic [1:0] state;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned nfail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  exp_t sbq[$];

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (PR),
    .LOCK_STABLE_CYCLES  (ST),
    .LOCK_TIMEOUT_CYCLES (TO),
    .CNT_W               (8)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .timeout       (timeout),
    .lock_lost_cnt (lock_lost_cnt),
    .state         (state)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      nfail++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) passed++;
      else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic wait_run(input int budget, output bit ok);
    int k = 0;
    while (state != 2'd3 && k < budget) begin
      tick();
      k++;
    end
    ok = (state == 2'd3);
  endtask

  task automatic wait_not_run(input int budget, output bit ok);
    int k = 0;
    while (state == 2'd3 && k < budget) begin
      tick();
      k++;
    end
    ok = (state != 2'd3);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_pll;
    int  n_wait;
    int  first_rdy;
    int  bound_miss;
    bit  ok;

    rst        = 1'b1;
    pll_locked = 1'b1;
    relock_req = 1'b0;

    // ---------------- Clean lock from reset ----------------
    push("rst_state", 32'd0);
    push("rst_pll_rst", 32'd1);
    push("rst_sys_rst", 32'd1);
    push("rst_ready", 32'd0);
    push("rst_timeout", 32'd0);
    push("rst_lost", 32'd0);
    repeat (3) tick();
    pop_chk({30'd0, state});
    pop_chk({31'd0, pll_rst});
    pop_chk({31'd0, sys_rst});
    pop_chk({31'd0, ready});
    pop_chk({31'd0, timeout});
    pop_chk({24'd0, lock_lost_cnt});

    push("clean_pll_rst_cycles", PR);
    push("clean_ready_cycle", PR + 1 + ST);
    push("clean_timeout", 32'd0);
    push("clean_lost", 32'd0);
    n_pll     = pll_rst ? 1 : 0;
    first_rdy = -1;
    rst       = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pll_rst) n_pll++;
      if (ready && first_rdy < 0) first_rdy = k;
    end
    pop_chk(n_pll);
    pop_chk(first_rdy);
    pop_chk({31'd0, timeout});
    pop_chk({24'd0, lock_lost_cnt});

    // ---------------- Glitch during STABLE ----------------
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    push("glitch_in_stable", 32'd2);
    repeat (10) tick();                 // STABLE entered at edge 5, cnt=5 now
    pop_chk({30'd0, state});
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    push("glitch_back_to_wait", 32'd1);
    repeat (2) tick();                  // edge 13
    pop_chk({30'd0, state});
    push("glitch_ready_cycle", 32'd22);
    push("glitch_lost", 32'd0);
    first_rdy = -1;
    for (int k = 14; k <= 40; k++) begin
      tick();
      if (ready && first_rdy < 0) first_rdy = k;
    end
    pop_chk(first_rdy);
    pop_chk({24'd0, lock_lost_cnt});

    // ---------------- WAIT_LOCK timeout ----------------
    rst        = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    rst    = 1'b0;
    n_wait = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (state == 2'd1) n_wait++;
    end
    push("to_wait_cycles", TO);
    push("to_before_flag", 32'd0);
    push("to_state_after", 32'd0);
    push("to_flag_set", 32'd1);
    pop_chk(n_wait);
    pop_chk({31'd0, timeout});
    tick();                             // edge 36
    pop_chk({30'd0, state});
    pop_chk({31'd0, timeout});
    push("to_pll_rst_cycles", PR);
    push("to_flag_sticky", 32'd1);
    push("to_back_to_wait", 32'd1);
    n_pll = pll_rst ? 1 : 0;
    for (int k = 37; k <= 45; k++) begin
      tick();
      if (pll_rst) n_pll++;
    end
    pop_chk(n_pll);
    pop_chk({31'd0, timeout});
    pop_chk({30'd0, state});

    pll_locked = 1'b1;
    push("to_recover_run", 32'd1);
    wait_run(100, ok);
    pop_chk({31'd0, ok});

    // ---------------- Lock loss in RUN ----------------
    push("loss_e1_sys_rst", 32'd0);
    push("loss_e2_sys_rst", 32'd0);
    push("loss_e3_sys_rst", 32'd1);
    push("loss_lost_cnt", 32'd1);
    push("loss_target_state", LOSS_STATE);
    pll_locked = 1'b0;
    tick();
    pop_chk({31'd0, sys_rst});
    tick();
    pop_chk({31'd0, sys_rst});
    tick();
    pop_chk({31'd0, sys_rst});
    pop_chk({24'd0, lock_lost_cnt});
    pop_chk({30'd0, state});
    push("loss_pll_rst_cycles", LOSS_PULSE);
    n_pll = pll_rst ? 1 : 0;
    for (int k = 4; k <= 12; k++) begin
      tick();
      if (pll_rst) n_pll++;
    end
    pop_chk(n_pll);
    pll_locked = 1'b1;
    push("loss_recover_run", 32'd1);
    wait_run(100, ok);
    pop_chk({31'd0, ok});

    // ---------------- Relock request in RUN ----------------
    push("relock_state", 32'd0);
    push("relock_lost_unchanged", 32'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    pop_chk({30'd0, state});
    pop_chk({24'd0, lock_lost_cnt});
    push("relock_recover_run", 32'd1);
    wait_run(100, ok);
    pop_chk({31'd0, ok});

    // ---------------- Relock together with lock loss ----------------
    push("both_lost_cnt", 32'd2);
    push("both_target_state", LOSS_STATE);
    pll_locked = 1'b0;
    repeat (2) tick();
    relock_req = 1'b1;                  // coincides with locked_s going low
    tick();
    relock_req = 1'b0;
    pop_chk({24'd0, lock_lost_cnt});
    pop_chk({30'd0, state});
    pll_locked = 1'b1;
    push("both_recover_run", 32'd1);
    wait_run(100, ok);
    pop_chk({31'd0, ok});

    // ---------------- Saturation over 300 losses ----------------
    bound_miss = 0;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_not_run(20, ok);
      if (!ok) bound_miss++;
      pll_locked = 1'b1;
      wait_run(100, ok);
      if (!ok) bound_miss++;
    end
    push("sat_bound_misses", 32'd0);
    push("sat_lost_cnt", 32'd255);
    pop_chk(bound_miss);
    pop_chk({24'd0, lock_lost_cnt});

    // ---------------- Reset asserted in STABLE ----------------
    // timeout is still set from the timeout phase; lost count is saturated.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    n_wait = 0;
    while (state != 2'd2 && n_wait < 20) begin
      tick();
      n_wait++;
    end
    push("mid_in_stable", 32'd2);
    push("mid_pre_timeout", 32'd1);
    push("mid_pre_lost", 32'd255);
    pop_chk({30'd0, state});
    pop_chk({31'd0, timeout});
    pop_chk({24'd0, lock_lost_cnt});
    push("mid_state", 32'd0);
    push("mid_pll_rst", 32'd1);
    push("mid_sys_rst", 32'd1);
    push("mid_ready", 32'd0);
    push("mid_timeout", 32'd0);
    push("mid_lost", 32'd0);
    rst = 1'b1;
    tick();
    pop_chk({30'd0, state});
    pop_chk({31'd0, pll_rst});
    pop_chk({31'd0, sys_rst});
    pop_chk({31'd0, ready});
    pop_chk({31'd0, timeout});
    pop_chk({24'd0, lock_lost_cnt});
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
